vga_vram_arbiter: RTL

Single-port video-RAM arbiter that shares one synchronous framebuffer RAM between the VGA scan-out fetch engine and the CPU bus port. It sits between the pixel-fetch logic feeding the VGA sync/stream stage and the framebuffer, giving scan-out priority during active video. A saturating starvation counter guarantees CPU forward progress. It tags every granted access and routes the 1-cycle-latency read response back to its owner.

---
 rtl/vga_vram_arbiter_if.sv | 50 +++++
 rtl/vga_vram_arbiter.sv | 81 ++++++++
 2 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Shared framebuffer port bundle: scan-out fetch, CPU bus and RAM sides.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface vga_vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic            blank;

  logic            scan_req;
  logic [AW-1:0]   scan_addr;
  logic            scan_gnt;
  logic            scan_rvalid;
  logic [DW-1:0]   scan_rdata;

  logic            cpu_req;
  logic            cpu_we;
  logic [DW/8-1:0] cpu_be;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_gnt;
  logic            cpu_rvalid;
  logic [DW-1:0]   cpu_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  blank,
    input  scan_req, scan_addr,
    output scan_gnt, scan_rvalid, scan_rdata,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output blank,
    output scan_req, scan_addr,
    input  scan_gnt, scan_rvalid, scan_rdata,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: scan-out wins during active video, a saturating
// starvation counter hands the CPU one slot after STARVE_MAX denials.
module vga_vram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input logic                clk,
  input logic                reset,
  vga_vram_arbiter_if.slave  bus
);
  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_SCAN = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  tag_t            tag_q, tag_d;
  logic [CW-1:0]   starve_cnt;
  logic            cpu_win, cpu_gnt, scan_gnt;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  always_comb begin
    cpu_win  = bus.cpu_req & (~bus.scan_req | bus.blank | (starve_cnt == CNT_MAX));
    cpu_gnt  = ~reset & cpu_win;
    scan_gnt = ~reset & bus.scan_req & ~cpu_win;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = {(DW/8){1'b1}};
    mem_addr  = bus.scan_addr;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = bus.cpu_we;
      mem_be    = bus.cpu_be;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (cpu_gnt)       tag_d = TAG_CPU;
    else if (scan_gnt) tag_d = TAG_SCAN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= TAG_NONE;
    else       tag_q <= tag_d;
  end

  // Clear beats increment when the CPU is granted in a conflict cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (cpu_gnt)
      starve_cnt <= '0;
    else if (bus.cpu_req && !bus.blank && bus.scan_req && starve_cnt != CNT_MAX)
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign bus.scan_gnt    = scan_gnt;
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.mem_en      = scan_gnt | cpu_gnt;
  assign bus.mem_we      = mem_we;
  assign bus.mem_be      = mem_be;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.scan_rvalid = (tag_q == TAG_SCAN);
  assign bus.cpu_rvalid  = (tag_q == TAG_CPU);
  assign bus.scan_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata   = bus.mem_rdata;
endmodule
